// File: rtl/img_proc_pkg.sv
// Shared image-processing types and helpers.
// Holds the line replication controller's state encoding and the repeat-count clamp.
package img_proc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        STREAM = 3'd2,
        GAP    = 3'd3,
        FLUSH  = 3'd4
    } line_repeat_state_t;

    // A request of 0 replicas still shows the line once; requests above max_rep saturate.
    function automatic int unsigned clamp_repeat(input int unsigned req, input int unsigned max_rep);
        int unsigned clamped;
        clamped = req;
        if (req == 0) begin
            clamped = 1;
        end else if (req > max_rep) begin
            clamped = max_rep;
        end
        return clamped;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
// A beat transfers on a rising clock edge where tvalid && tready; once tvalid is raised the master holds it and the payload until that beat transfers.
interface axi4_stream_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DEST_WIDTH = 4
);

    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tuser;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        output tready
    );

endinterface

// File: rtl/line_repeat_ctrl.sv
// Read-side controller for line_buf: replays each stored line a programmable number of times,
// then flushes it, forwarding the replayed pixels downstream (integer vertical upscaling).
module line_repeat_ctrl
    import img_proc_pkg::*;
#(
    parameter  int unsigned TDATA_WIDTH  = 32,
    parameter  int unsigned MAX_REPEAT   = 8,
    localparam int unsigned REPEAT_WIDTH = $clog2(MAX_REPEAT + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [REPEAT_WIDTH-1:0] repeat_i,
    input  logic                    sof_i,
    input  logic                    empty_i,
    input  logic                    unread_i,
    output logic                    pop_line_o,
    output logic                    flush_line_o,
    output logic                    busy_o,
    output line_repeat_state_t      state_o,
    axi4_stream_if.slave            video_i,
    axi4_stream_if.master           video_o
);

    line_repeat_state_t r_state;
    line_repeat_state_t w_next_state;

    logic [REPEAT_WIDTH-1:0] r_rep_total;
    logic [REPEAT_WIDTH-1:0] r_rep_cnt;
    logic [REPEAT_WIDTH-1:0] w_rep_total_next;
    logic [REPEAT_WIDTH-1:0] w_rep_cnt_next;
    logic [REPEAT_WIDTH-1:0] w_rep_clamped;

    logic r_pop;
    logic r_flush;

    logic w_in_stream;
    logic w_line_ready;
    logic w_last_beat;
    logic w_last_replica;
    logic w_unused_stream;

    assign w_in_stream    = (r_state == STREAM);
    assign w_line_ready   = unread_i && !empty_i;
    assign w_last_beat    = w_in_stream && video_i.tvalid && video_o.tready && video_i.tlast;
    assign w_last_replica = (r_rep_cnt == r_rep_total - REPEAT_WIDTH'(1));
    assign w_rep_clamped  = REPEAT_WIDTH'(clamp_repeat(32'(repeat_i), MAX_REPEAT));

    always_comb begin
        w_next_state     = r_state;
        w_rep_cnt_next   = r_rep_cnt;
        w_rep_total_next = r_rep_total;

        case (r_state)
            IDLE: begin
                if (w_line_ready) begin
                    w_next_state     = POP;
                    w_rep_total_next = w_rep_clamped;
                    w_rep_cnt_next   = '0;
                end
            end
            POP: begin
                w_next_state = STREAM;
            end
            STREAM: begin
                if (w_last_beat) begin
                    if (w_last_replica) begin
                        w_next_state = FLUSH;
                    end else begin
                        w_rep_cnt_next = r_rep_cnt + REPEAT_WIDTH'(1);
                        w_next_state   = GAP;
                    end
                end
            end
            GAP: begin
                w_next_state = POP;
            end
            FLUSH: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // line_buf discards its contents on SOF by itself, so an aborted line is never flushed.
        if (sof_i) begin
            w_next_state   = IDLE;
            w_rep_cnt_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_rep_cnt   <= '0;
            r_rep_total <= REPEAT_WIDTH'(1);
            r_pop       <= 1'b0;
            r_flush     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_rep_cnt   <= w_rep_cnt_next;
            r_rep_total <= w_rep_total_next;
            r_pop       <= (w_next_state == POP);
            r_flush     <= (w_next_state == FLUSH);
        end
    end

    assign pop_line_o   = r_pop;
    assign flush_line_o = r_flush;
    assign busy_o       = (r_state != IDLE);
    assign state_o      = r_state;

    // Only the first replica of a frame's first line carries the SOF mark.
    assign video_o.tvalid = w_in_stream && video_i.tvalid;
    assign video_o.tdata  = video_i.tdata;
    assign video_o.tlast  = video_i.tlast;
    assign video_o.tuser  = video_i.tuser && (r_rep_cnt == '0);
    assign video_o.tstrb  = {(TDATA_WIDTH/8){1'b1}};
    assign video_o.tkeep  = {(TDATA_WIDTH/8){1'b1}};
    assign video_o.tid    = '0;
    assign video_o.tdest  = '0;
    assign video_i.tready = w_in_stream && video_o.tready;

    assign w_unused_stream = ^{video_i.tstrb, video_i.tkeep, video_i.tid, video_i.tdest};

endmodule

// File: tb/tb_line_repeat_ctrl.sv
// Self-checking bench for line_repeat_ctrl: a small line_buf model feeds stored lines,
// and every replayed beat is compared against a replica list built from the replication rules.
module tb_line_repeat_ctrl;
    import img_proc_pkg::*;

    localparam int unsigned W       = 32;
    localparam int unsigned MAX_REP = 8;
    localparam int unsigned RW      = $clog2(MAX_REP + 1);
    localparam int unsigned SLOTS   = 8;
    localparam int unsigned MAX_LEN = 16;
    localparam int          TIMEOUT = 3000;

    logic               clk;
    logic               rst_i;
    logic               sof_i;
    logic               empty_i;
    logic               unread_i;
    logic [RW-1:0]      repeat_i;
    logic               pop_line_o;
    logic               flush_line_o;
    logic               busy_o;
    line_repeat_state_t state_o;

    axi4_stream_if #(.DATA_WIDTH(W)) vi ();
    axi4_stream_if #(.DATA_WIDTH(W)) vo ();

    line_repeat_ctrl #(
        .TDATA_WIDTH (W),
        .MAX_REPEAT  (MAX_REP)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .repeat_i     (repeat_i),
        .sof_i        (sof_i),
        .empty_i      (empty_i),
        .unread_i     (unread_i),
        .pop_line_o   (pop_line_o),
        .flush_line_o (flush_line_o),
        .busy_o       (busy_o),
        .state_o      (state_o),
        .video_i      (vi),
        .video_o      (vo)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stored lines (written by tests, read by line_buf model) ----------------
    logic [W-1:0] line_pix [SLOTS][MAX_LEN];
    int           line_len [SLOTS];
    bit           line_sof [SLOTS];
    int           load_seq = 0;
    bit           bp_mode  = 1'b0;

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];
    logic [W+1:0] got_q[$];
    int           pop_cnt   = 0;
    int           flush_cnt = 0;
    bit           src_fire_q;
    bit           sof_q;
    bit           rst_q;
    int           errors = 0;
    int           checks = 0;

    // Monitor: values read here are the ones present just before the edge.
    always @(posedge clk) begin
        src_fire_q <= vi.tvalid && vi.tready;
        sof_q      <= sof_i;
        rst_q      <= rst_i;
        if (vo.tvalid && vo.tready) got_q.push_back({vo.tuser, vo.tlast, vo.tdata});
        if (pop_line_o)   pop_cnt   <= pop_cnt + 1;
        if (flush_line_o) flush_cnt <= flush_cnt + 1;
    end

    // line_buf model: a stored line is unread until flushed; each pop replays it two cycles later.
    initial begin : line_buf_model
        bit present;
        bit src_active;
        int src_wait;
        int src_idx;
        int slot;
        int load_seen;
        present    = 1'b0;
        src_active = 1'b0;
        src_wait   = 0;
        src_idx    = 0;
        slot       = 0;
        load_seen  = 0;
        vi.tvalid  = 1'b0;
        vi.tdata   = '0;
        vi.tlast   = 1'b0;
        vi.tuser   = 1'b0;
        vi.tstrb   = '1;
        vi.tkeep   = '1;
        vi.tid     = '0;
        vi.tdest   = '0;
        vo.tready  = 1'b1;
        unread_i   = 1'b0;
        empty_i    = 1'b1;
        forever begin
            @(negedge clk);
            vo.tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sof_q || rst_q) begin
                present    = 1'b0;
                src_active = 1'b0;
                src_wait   = 0;
                vi.tvalid  = 1'b0;
            end else begin
                if (src_active && src_fire_q) begin
                    if (src_idx == line_len[slot] - 1) begin
                        src_active = 1'b0;
                        vi.tvalid  = 1'b0;
                    end else begin
                        src_idx  = src_idx + 1;
                        vi.tdata = line_pix[slot][src_idx];
                        vi.tlast = (src_idx == line_len[slot] - 1);
                        vi.tuser = 1'b0;
                    end
                end
                if (pop_line_o) begin
                    src_wait   = 2;
                    src_idx    = 0;
                    src_active = 1'b0;
                    vi.tvalid  = 1'b0;
                end else if (src_wait > 0) begin
                    src_wait = src_wait - 1;
                    if (src_wait == 0) begin
                        src_active = 1'b1;
                        vi.tvalid  = 1'b1;
                        vi.tdata   = line_pix[slot][0];
                        vi.tlast   = (line_len[slot] == 1);
                        vi.tuser   = line_sof[slot];
                    end
                end
                if (flush_line_o) present = 1'b0;
            end
            if (!present && load_seq != load_seen) begin
                slot      = load_seen % SLOTS;
                load_seen = load_seen + 1;
                present   = 1'b1;
            end
            unread_i = present;
            empty_i  = !present;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_line(input int len, input bit sof, input bit fixed,
                             input logic [W-1:0] first, output int slot);
        slot = load_seq % SLOTS;
        for (int i = 0; i < len; i++) begin
            line_pix[slot][i] = fixed ? first + W'(i) : W'($urandom());
        end
        line_len[slot] = len;
        line_sof[slot] = sof;
        load_seq = load_seq + 1;
    endtask

    // Expected output: the whole line repeated clamp(rep) times, SOF only on replica 0 pixel 0.
    task automatic expect_line(input int slot, input int rep_req);
        int reps;
        reps = (rep_req == 0) ? 1 : ((rep_req > int'(MAX_REP)) ? int'(MAX_REP) : rep_req);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < line_len[slot]; i++) begin
                exp_q.push_back({line_sof[slot] && r == 0 && i == 0,
                                 i == line_len[slot] - 1,
                                 line_pix[slot][i]});
            end
        end
    endtask

    task automatic pulse_sof();
        @(negedge clk);
        sof_i = 1'b1;
        @(negedge clk);
        sof_i = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i    = 1'b1;
        sof_i    = 1'b0;
        repeat_i = RW'(1);
        repeat (4) @(negedge clk);
        checks++; if (pop_line_o !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", pop_line_o); end
        checks++; if (flush_line_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush_line_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (state_o !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", state_o); end
        checks++; if (vo.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", vo.tvalid); end
        checks++; if (vi.tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", vi.tready); end
        checks++; if (vo.tkeep !== '1 || vo.tstrb !== '1 || vo.tid !== '0 || vo.tdest !== '0) begin
            errors++; $display("FAIL reset_sideband: keep=%h strb=%h id=%h dest=%h want f f 0 0", vo.tkeep, vo.tstrb, vo.tid, vo.tdest);
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_repeat3();
        int slot, base, pop0, fl0;
        bp_mode = 1'b0;
        repeat_i = RW'(3);
        exp_q.delete();
        base = got_q.size(); pop0 = pop_cnt; fl0 = flush_cnt;
        load_line(4, 1'b0, 1'b1, W'(32'hA), slot);
        expect_line(slot, 3);
        for (int c = 0; c < TIMEOUT && flush_cnt < fl0 + 1; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++; if (flush_cnt - fl0 !== 1) begin errors++; $display("FAIL repeat3_flush: got %0d want 1", flush_cnt - fl0); end
        checks++; if (pop_cnt - pop0 !== 3) begin errors++; $display("FAIL repeat3_pops: got %0d want 3", pop_cnt - pop0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL repeat3_idle: busy %b want 0", busy_o); end
        checks++; if (got_q.size() - base !== exp_q.size()) begin
            errors++; $display("FAIL repeat3_count: got %0d beats want %0d", got_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base+i] !== exp_q[i]) begin
                errors++; $display("FAIL repeat3_beat[%0d]: got %h want %h", i, got_q[base+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_sof();
        int slot, base, fl0;
        bp_mode = 1'b0;
        repeat_i = RW'(2);
        pulse_sof();
        exp_q.delete();
        base = got_q.size(); fl0 = flush_cnt;
        load_line($urandom_range(3, 8), 1'b1, 1'b0, '0, slot);
        expect_line(slot, 2);
        for (int c = 0; c < TIMEOUT && flush_cnt < fl0 + 1; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++; if (flush_cnt - fl0 !== 1) begin errors++; $display("FAIL sof_flush: got %0d want 1", flush_cnt - fl0); end
        checks++; if (got_q.size() - base !== exp_q.size()) begin
            errors++; $display("FAIL sof_count: got %0d beats want %0d", got_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base+i] !== exp_q[i]) begin
                errors++; $display("FAIL sof_beat[%0d]: got %h want %h", i, got_q[base+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clamp();
        int reqs [2];
        int wants [2];
        reqs[0] = 0;  wants[0] = 1;
        reqs[1] = 15; wants[1] = int'(MAX_REP);
        bp_mode = 1'b0;
        for (int t = 0; t < 2; t++) begin
            int slot, base, pop0, fl0;
            repeat_i = RW'(reqs[t]);
            exp_q.delete();
            base = got_q.size(); pop0 = pop_cnt; fl0 = flush_cnt;
            load_line($urandom_range(1, 5), 1'b0, 1'b0, '0, slot);
            expect_line(slot, reqs[t]);
            for (int c = 0; c < TIMEOUT && flush_cnt < fl0 + 1; c++) @(negedge clk);
            repeat (4) @(negedge clk);
            checks++; if (pop_cnt - pop0 !== wants[t]) begin
                errors++; $display("FAIL clamp_pops(req=%0d): got %0d want %0d", reqs[t], pop_cnt - pop0, wants[t]);
            end
            checks++; if (got_q.size() - base !== exp_q.size()) begin
                errors++; $display("FAIL clamp_count(req=%0d): got %0d beats want %0d", reqs[t], got_q.size() - base, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
                checks++; if (got_q[base+i] !== exp_q[i]) begin
                    errors++; $display("FAIL clamp_beat[%0d]: got %h want %h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bp_mode = 1'b1;
        for (int t = 0; t < 3; t++) begin
            int slot, base, fl0, rep;
            rep = (t == 0) ? 2 : int'($urandom_range(1, MAX_REP));
            repeat_i = RW'(rep);
            exp_q.delete();
            base = got_q.size(); fl0 = flush_cnt;
            load_line($urandom_range(2, MAX_LEN), t == 0, 1'b0, '0, slot);
            expect_line(slot, rep);
            for (int c = 0; c < TIMEOUT && flush_cnt < fl0 + 1; c++) @(negedge clk);
            repeat (4) @(negedge clk);
            checks++; if (flush_cnt - fl0 !== 1) begin errors++; $display("FAIL bp_flush(rep=%0d): got %0d want 1", rep, flush_cnt - fl0); end
            checks++; if (got_q.size() - base !== exp_q.size()) begin
                errors++; $display("FAIL bp_count(rep=%0d): got %0d beats want %0d", rep, got_q.size() - base, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
                checks++; if (got_q[base+i] !== exp_q[i]) begin
                    errors++; $display("FAIL bp_beat[%0d]: got %h want %h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
        bp_mode = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Second line is queued before the first finishes; repeat_i changes mid-line.
    task automatic test_back_to_back();
        int slot_a, slot_b, base, pop0, fl0;
        bp_mode = 1'b0;
        repeat_i = RW'(2);
        exp_q.delete();
        base = got_q.size(); pop0 = pop_cnt; fl0 = flush_cnt;
        load_line($urandom_range(2, 6), 1'b0, 1'b0, '0, slot_a);
        load_line($urandom_range(2, 6), 1'b0, 1'b0, '0, slot_b);
        expect_line(slot_a, 2);
        expect_line(slot_b, 3);
        for (int c = 0; c < TIMEOUT && pop_cnt == pop0; c++) @(negedge clk);
        repeat_i = RW'(3);
        for (int c = 0; c < TIMEOUT && flush_cnt < fl0 + 2; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++; if (flush_cnt - fl0 !== 2) begin errors++; $display("FAIL b2b_flush: got %0d want 2", flush_cnt - fl0); end
        checks++; if (pop_cnt - pop0 !== 5) begin errors++; $display("FAIL b2b_pops: got %0d want 5", pop_cnt - pop0); end
        checks++; if (got_q.size() - base !== exp_q.size()) begin
            errors++; $display("FAIL b2b_count: got %0d beats want %0d", got_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base+i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_beat[%0d]: got %h want %h", i, got_q[base+i], exp_q[i]);
            end
        end
    endtask

    // SOF during the 2nd pixel of replica 1: that pixel still transfers, then the line is dropped.
    task automatic test_abort();
        int slot, base, pop0, fl0, len;
        bp_mode = 1'b0;
        repeat_i = RW'(2);
        len = 6;
        exp_q.delete();
        base = got_q.size(); pop0 = pop_cnt; fl0 = flush_cnt;
        load_line(len, 1'b0, 1'b0, '0, slot);
        expect_line(slot, 2);
        for (int c = 0; c < TIMEOUT && got_q.size() - base < len + 1; c++) @(negedge clk);
        checks++; if (got_q.size() - base !== len + 1) begin
            errors++; $display("FAIL abort_reach: got %0d beats want %0d", got_q.size() - base, len + 1);
        end
        sof_i = 1'b1;
        @(negedge clk);
        sof_i = 1'b0;
        checks++; if (state_o !== IDLE) begin errors++; $display("FAIL abort_state: got %0d want IDLE", state_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_o); end
        repeat (12) @(negedge clk);
        checks++; if (flush_cnt !== fl0) begin errors++; $display("FAIL abort_noflush: got %0d flushes want 0", flush_cnt - fl0); end
        checks++; if (pop_cnt - pop0 !== 2) begin errors++; $display("FAIL abort_pops: got %0d want 2", pop_cnt - pop0); end
        checks++; if (got_q.size() - base !== len + 2) begin
            errors++; $display("FAIL abort_count: got %0d beats want %0d", got_q.size() - base, len + 2);
        end
        for (int i = 0; i < len + 2 && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base+i] !== exp_q[i]) begin
                errors++; $display("FAIL abort_beat[%0d]: got %h want %h", i, got_q[base+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int slot, base, fl0;
        bp_mode = 1'b0;
        repeat_i = RW'(3);
        base = got_q.size(); fl0 = flush_cnt;
        load_line(8, 1'b0, 1'b0, '0, slot);
        for (int c = 0; c < TIMEOUT && got_q.size() - base < 2; c++) @(negedge clk);
        checks++; if (state_o !== STREAM) begin errors++; $display("FAIL rstmid_reach: state %0d want STREAM", state_o); end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checks++; if (state_o !== IDLE) begin errors++; $display("FAIL rstmid_state: got %0d want IDLE", state_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
        checks++; if (pop_line_o !== 1'b0 || flush_line_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_pulses: pop=%b flush=%b want 0 0", pop_line_o, flush_line_o);
        end
        checks++; if (vo.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b want 0", vo.tvalid); end
        repeat (10) @(negedge clk);
        checks++; if (flush_cnt !== fl0) begin errors++; $display("FAIL rstmid_noflush: got %0d flushes want 0", flush_cnt - fl0); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_repeat3();
        test_sof();
        test_clamp();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_repeat_ctrl.md
# line_repeat_ctrl

Read-side controller for `line_buf`: watches the buffer's `empty_o`/`unread_o` flags and issues `pop_line_i` to replay each stored line a programmable number of times. It then issues `flush_line_i` so the buffer accepts the next line. It forwards the replayed pixels downstream as AXI4-Stream. It sits between `line_buf.video_o` and the next stage and implements integer vertical upscaling (line replication).

## Interface
- `TDATA_WIDTH`, 32, width of `tdata` on both stream interfaces.
- `MAX_REPEAT`, 8, maximum replications per line; `REPEAT_WIDTH = $clog2( MAX_REPEAT + 1 )` is a localparam.
- `clk_i`  in  1  single clock for the whole block.
- `rst_i`  in  1  reset, synchronous and active-high.
- `repeat_i`  in  REPEAT_WIDTH  replications per line.
  - Sampled only when leaving IDLE.
  - 0 is treated as 1; values above `MAX_REPEAT` are clamped to `MAX_REPEAT`.
- `sof_i`  in  1  start-of-frame strobe: `tuser && tvalid` at the `line_buf` input.
- `empty_i`  in  1  from `line_buf.empty_o`.
- `unread_i`  in  1  from `line_buf.unread_o`.
- `pop_line_o`  out  1  to `line_buf.pop_line_i`; registered, one-cycle pulse.
- `flush_line_o`  out  1  to `line_buf.flush_line_i`; registered, one-cycle pulse.
- `busy_o`  out  1  high in every state except IDLE.
- `video_i`  `axi4_stream_if.slave`  connected to `line_buf.video_o`.
- `video_o`  `axi4_stream_if.master`  replicated line stream.

## Operation
- FSM states: IDLE, POP, STREAM, GAP, FLUSH.
- IDLE → POP when `unread_i && !empty_i`.
  - Latch `rep_total` = clamped `repeat_i`.
  - Clear `rep_cnt` to 0.
- POP: `pop_line_o` = 1 for exactly this cycle; → STREAM.
- STREAM:
  - `video_o.tvalid/tdata/tlast` = `video_i` (combinational pass-through).
  - `video_i.tready` = `video_o.tready`.
  - On a beat with `tlast` (`tvalid && tready && tlast`):
    - If `rep_cnt == rep_total - 1`, → FLUSH.
    - Otherwise `rep_cnt++` and → GAP.
- GAP: one idle cycle so `line_buf` can clear its read state; → POP.
- FLUSH: `flush_line_o` = 1 for exactly this cycle; → IDLE.
- `video_o.tuser` = `video_i.tuser && rep_cnt == 0`: the SOF mark appears only on the first replica.
- Outside STREAM: `video_o.tvalid` = 0 and `video_i.tready` = 0.
- `tstrb`/`tkeep` are all ones; `tid`/`tdest` are 0.
- `sof_i` has priority over every transition.
  - Next state is IDLE and `rep_cnt` clears to 0.
  - No flush is issued, because `line_buf` self-clears on SOF.
  - A line truncated mid-stream is not completed or padded.

## Timing
- Reset values: `pop_line_o` 0, `flush_line_o` 0, `busy_o` 0, state IDLE, `rep_cnt` 0, `video_o.tvalid` 0.
- A reset asserted mid-line aborts immediately, with no flush.
- `pop_line_o` rises the cycle after `unread_i && !empty_i` is seen in IDLE.
- The first `video_o` beat appears no earlier than 2 cycles after `pop_line_o`, set by `line_buf` latency.
- Overhead per replica is 2 cycles (POP + GAP) on top of the line length.
- Overhead per stored line adds 1 cycle for FLUSH.
- `repeat_i` changing during a line has no effect until the next IDLE exit.
- `unread_i` going high while in FLUSH is handled in IDLE on the next cycle; no line is lost.
- Backpressure: `video_o.tready` low holds STREAM indefinitely, and `rep_cnt` is unchanged.

## Structure
- Shared package `img_proc_pkg` gains the `line_repeat_state_t` enum (IDLE, POP, STREAM, GAP, FLUSH).
- The clamp of `repeat_i` is a package function `clamp_repeat`.
- There is no sub-module. The block is the FSM plus a counter and combinational stream gating.
- It is instantiated alongside one `line_buf`.

## Test plan
- Replication ×3:
  - Stimulus: `repeat_i`=3; a 4-pixel line 0xA,0xB,0xC,0xD; `video_o.tready`=1.
  - Required: the line appears 3 times with `tlast` on each 0xD.
  - Required: `pop_line_o` pulses 3 times, then `flush_line_o` pulses once.
- SOF handling:
  - Stimulus: the first line after a frame start, with `repeat_i`=2.
  - Required: `video_o.tuser`=1 only on the first beat of replica 0, 0 on replica 1.
- Clamp/zero:
  - Stimulus: `repeat_i`=0, then `repeat_i`=15 with `MAX_REPEAT`=8.
  - Required: 1 replica, then 8 replicas.
- Backpressure:
  - Stimulus: `repeat_i`=2; `video_o.tready` toggled randomly at 50%.
  - Required: the output data sequence is identical to the no-stall case; no duplicated or dropped beat.
- Mid-line abort:
  - Stimulus: `sof_i` pulsed during the 2nd pixel of replica 1.
  - Required: next cycle state is IDLE, `busy_o`=0, and no `flush_line_o` is issued.
- Reset:
  - Stimulus: `rst_i` asserted during STREAM.
  - Required: all outputs return to their reset values on the next clock edge.
